if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch unit: the producer side of the decode-stage interface. It reads each 32-bit instruction from the shared byte-wide memory port as four little-endian byte reads and presents the assembled `inst_o` and `pc_o` to the IF/ID boundary with a valid/ready handshake. It redirects on branch/jump requests from the execute/control path and discards any in-flight byte data from the old path.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1: clock, all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `mem_req_o`  out  1: byte read request.
- `mem_addr_o`  out  32: byte address of the request.
- `mem_gnt_i`  in  1: arbiter accepts the request this cycle.
- `mem_rdata_i`  in  8: read data, valid exactly one cycle after a granted request.
- `br_flag_i`  in  1: redirect fetch this cycle.
- `br_target_i`  in  32: redirect address; bits [1:0] are ignored and forced to 0.
- `inst_valid_o`  out  1: `inst_o`/`pc_o` hold a complete instruction.
- `inst_ready_i`  in  1: decode side accepts; low means stall.
- `pc_o`  out  32: address of `inst_o`.
- `inst_o`  out  32: assembled instruction.

## Operation
- States:
  - IDLE: first cycle after reset.
  - REQ: issuing bytes `req_idx` 0..3.
  - DRAIN: waiting for the byte-3 response.
  - HOLD: instruction valid.
- Transitions:
  - IDLE -> REQ unconditionally.
  - REQ issues `mem_req_o`=1 with `mem_addr_o` = `pc` + `req_idx` (32-bit modulo). On `mem_gnt_i`, `req_idx` increments. With `req_idx`=3 granted, the state goes to DRAIN.
  - Without a grant, the request and address stay unchanged.
  - DRAIN -> HOLD when the byte-3 response is captured.
  - HOLD -> REQ on `inst_valid_o` & `inst_ready_i`. At the same time, `pc` <= `pc`+4 (wraps 0xFFFF_FFFC -> 0x0) and `req_idx` <= 0.
- Response tracking:
  - `resp_valid` register <= `mem_req_o` & `mem_gnt_i` & ~`br_flag_i`.
  - `resp_idx` register <= `req_idx`.
  - A byte is written into `inst_buf[8*resp_idx+7 : 8*resp_idx]` only when `resp_valid`=1.
- `mem_req_o` = 1 only in REQ. `inst_valid_o` = 1 only in HOLD.
- `inst_o`/`pc_o` reflect `inst_buf`/`pc`. They are stable whenever `inst_valid_o`=1 and no transfer or redirect occurs.
- Redirect (`br_flag_i`=1, any state except IDLE):
  - `pc` <= {`br_target_i`[31:2], 2'b00}, `req_idx` <= 0, state <= REQ.
  - `inst_valid_o` drops next cycle.
  - The response arriving the cycle after the redirect is discarded (through `resp_valid`).
- Redirect together with a transfer in HOLD: the transfer counts as completed, and `pc` takes the target, not `pc`+4.
- Redirect in IDLE: ignored; the fetch starts at `RESET_PC`.
- Reset values: `mem_req_o` 0, `mem_addr_o` `RESET_PC`, `inst_valid_o` 0, `pc_o` `RESET_PC`, `inst_o` 32'h0.
  - Internally: state IDLE, `req_idx` 0, `resp_valid` 0.
- Reset has priority over everything, including a fetch or redirect in progress.

## Timing
- With continuous grant and the first request in cycle c0:
  - bytes 0..3 are granted in c0..c3;
  - byte k is captured at the end of cycle c(k+1);
  - DRAIN is in c4;
  - `inst_valid_o`=1 from c5.
- Each cycle `mem_gnt_i`=0 in REQ adds one cycle of latency.
- Acceptance at the end of c_n puts REQ with the new address in c_n+1. No prefetch; steady-state throughput is one instruction per 6 cycles.
- Redirect sampled at the end of cycle t gives `mem_req_o` with the target address in t+1.

## Structure
- Shared defines/package:
  - state encodings IDLE/REQ/DRAIN/HOLD;
  - `ZeroWord`;
  - `InstAddrBus`/`InstBus` widths;
  - `RstEnable` polarity.
- The module is flat: the FSM, the `req_idx`/`resp_idx` counters and the 32-bit byte-lane assembly register share the same control signals. No sub-module is warranted.

## Test plan
- Reset: hold `rst` for 2 cycles, then memory bytes 0x13,0x05,0x10,0x00 at 0x0..0x3 with constant grant.
  - Requires: `mem_addr_o` 0,1,2,3 in c0..c3 (c0 = cycle after IDLE), `inst_o`=0x0010_0513, `pc_o`=0x0, `inst_valid_o`=1 at c5.
- `mem_gnt_i` low for 2 cycles while `req_idx`=2.
  - Requires: `mem_addr_o` held at 0x2, no byte captured in that period, valid at c7, same instruction word.
- `inst_ready_i` low for 3 cycles in HOLD.
  - Requires: `inst_o`/`pc_o` stable, `mem_req_o`=0. After ready rises, the next request is at address 0x4.
- Redirect with target 0x103 in the cycle byte 1 is granted.
  - Requires: next request at 0x100; the stale byte-1 response is not written; the instruction comes from 0x100..0x103.
- Redirect to 0x200 in HOLD with `inst_ready_i`=1.
  - Requires: transfer completes and the next fetch address is 0x200, not `pc`+4.
- `RESET_PC`=0xFFFF_FFFC.
  - Requires: addresses 0xFFFF_FFFC..0xFFFF_FFFF, then the next fetch at 0x0.
- `rst` asserted mid-REQ.
  - Requires: all outputs at reset values the next cycle; the fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, reset
// polarity, FSM state encodings and small address helpers.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int ByteBus     = 8;

  localparam logic [InstBus-1:0] ZeroWord  = '0;
  localparam logic               RstEnable = 1'b1;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_t;

  // Byte lane index within one 32-bit instruction word.
  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t LastByte = 2'd3;

  // Force an address onto a word boundary.
  function automatic logic [InstAddrBus-1:0] word_align(
    input logic [InstAddrBus-1:0] addr
  );
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction

  // Sequential next-instruction address; wraps modulo 2^32.
  function automatic logic [InstAddrBus-1:0] pc_incr(
    input logic [InstAddrBus-1:0] pc
  );
    return pc + 32'd4;
  endfunction

  // Byte address of lane idx of the word at pc; wraps modulo 2^32.
  function automatic logic [InstAddrBus-1:0] byte_addr(
    input logic [InstAddrBus-1:0] pc,
    input byte_idx_t              idx
  );
    return pc + {{(InstAddrBus-2){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch unit. Reads each instruction as four little-endian byte
// reads over a shared byte-wide memory port, assembles the word and offers it
// to decode with a valid/ready handshake. A redirect restarts the fetch at a
// word-aligned target and drops the byte response still in flight.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_rdata_i,
  input  logic        br_flag_i,
  input  logic [31:0] br_target_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  fetch_state_t           state;
  fetch_state_t           state_next;
  logic [InstAddrBus-1:0] pc;
  logic [InstAddrBus-1:0] pc_next;
  byte_idx_t              req_idx;
  byte_idx_t              req_idx_next;

  logic                   resp_vld_p1;
  byte_idx_t              resp_idx_p1;
  logic [InstBus-1:0]     inst_buf;

  logic                   redirect;
  logic [InstAddrBus-1:0] redirect_pc;
  logic                   unused_tgt_lsb;

  // The low target bits never reach the PC; keep them visibly consumed.
  assign unused_tgt_lsb = ^br_target_i[1:0];

  // A redirect arriving while still in IDLE is ignored so the very first
  // fetch always starts at RESET_PC.
  assign redirect    = br_flag_i && (state != ST_IDLE);
  assign redirect_pc = word_align(br_target_i);

  // FSM state register plus the fetch PC and byte request index.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      req_idx <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      req_idx <= req_idx_next;
    end
  end

  // Next-state, next-PC and handshake outputs; redirect overrides the rest.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    req_idx_next = req_idx;
    mem_req_o    = 1'b0;
    inst_valid_o = 1'b0;

    case (state)
      ST_IDLE: begin
        state_next = ST_REQ;
      end

      ST_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          req_idx_next = req_idx + 2'd1;
          if (req_idx == LastByte) begin
            state_next = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (resp_vld_p1 && (resp_idx_p1 == LastByte)) begin
          state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        inst_valid_o = 1'b1;
        if (inst_ready_i) begin
          pc_next      = pc_incr(pc);
          req_idx_next = '0;
          state_next   = ST_REQ;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A redirect coinciding with a HOLD transfer still completes the
    // transfer; only the next PC changes from pc+4 to the target.
    if (redirect) begin
      pc_next      = redirect_pc;
      req_idx_next = '0;
      state_next   = ST_REQ;
    end
  end

  // ---- stage p1: granted request -> byte response one cycle later ----
  // A grant in the same cycle as a redirect belongs to the abandoned path,
  // so its response is marked invalid here and never reaches inst_buf.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      resp_vld_p1 <= 1'b0;
      resp_idx_p1 <= '0;
    end else begin
      resp_vld_p1 <= mem_req_o && mem_gnt_i && !br_flag_i;
      resp_idx_p1 <= req_idx;
    end
  end

  // ---- stage p2: little-endian byte lane assembly ----
  // The assembly register is cleared by reset so inst_o starts at zero.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      inst_buf <= ZeroWord;
    end else if (resp_vld_p1) begin
      inst_buf[8*resp_idx_p1 +: ByteBus] <= mem_rdata_i;
    end
  end

  assign mem_addr_o = byte_addr(pc, req_idx);
  assign pc_o       = pc;
  assign inst_o     = inst_buf;

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch: one instance fetching from address 0 and
// a second instance whose reset PC sits at the top of the address space.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_rdata;
  logic        br_flag;
  logic [31:0] br_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc;
  logic [31:0] inst;

  logic        rst_w;
  logic        mem_req_w;
  logic [31:0] mem_addr_w;
  logic        mem_gnt_w;
  logic [7:0]  mem_rdata_w;
  logic        inst_valid_w;
  logic        inst_ready_w;
  logic [31:0] pc_w;
  logic [31:0] inst_w;
  logic        br_flag_w;
  logic [31:0] br_target_w;

  int n_chk;
  int n_pass;

  if_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_rdata_i  (mem_rdata),
    .br_flag_i    (br_flag),
    .br_target_i  (br_target),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .pc_o         (pc),
    .inst_o       (inst)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk          (clk),
    .rst          (rst_w),
    .mem_req_o    (mem_req_w),
    .mem_addr_o   (mem_addr_w),
    .mem_gnt_i    (mem_gnt_w),
    .mem_rdata_i  (mem_rdata_w),
    .br_flag_i    (br_flag_w),
    .br_target_i  (br_target_w),
    .inst_valid_o (inst_valid_w),
    .inst_ready_i (inst_ready_w),
    .pc_o         (pc_w),
    .inst_o       (inst_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: a few hand-placed instruction words, a filler pattern elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'h13;
      32'h0000_0001: return 8'h05;
      32'h0000_0002: return 8'h10;
      32'h0000_0003: return 8'h00;
      32'h0000_0004: return 8'h93;
      32'h0000_0005: return 8'h00;
      32'h0000_0006: return 8'h10;
      32'h0000_0007: return 8'h00;
      32'h0000_0100: return 8'hB7;
      32'h0000_0101: return 8'h12;
      32'h0000_0102: return 8'h34;
      32'h0000_0103: return 8'h56;
      32'h0000_0200: return 8'h6F;
      32'h0000_0201: return 8'h00;
      32'h0000_0202: return 8'h00;
      32'h0000_0203: return 8'h00;
      32'hFFFF_FFFC: return 8'h11;
      32'hFFFF_FFFD: return 8'h22;
      32'hFFFF_FFFE: return 8'h33;
      32'hFFFF_FFFF: return 8'h44;
      default:       return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Advance one clock; the memory answers a granted request one cycle later,
  // and drives a junk byte when nothing was granted.
  task automatic tick();
    logic        p0, p1;
    logic [31:0] a0, a1;
    p0 = (mem_req === 1'b1) && (mem_gnt === 1'b1);
    a0 = mem_addr;
    p1 = (mem_req_w === 1'b1) && (mem_gnt_w === 1'b1);
    a1 = mem_addr_w;
    @(posedge clk);
    #1;
    mem_rdata   = p0 ? mem_byte(a0) : 8'hEE;
    mem_rdata_w = p1 ? mem_byte(a1) : 8'hEE;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;  mem_gnt = 1'b0;  inst_ready = 1'b0;  br_flag = 1'b0;
    br_target = 32'h0;  mem_rdata = 8'h00;
    rst_w = 1'b1;  mem_gnt_w = 1'b0;  inst_ready_w = 1'b1;  br_flag_w = 1'b0;
    br_target_w = 32'h0;  mem_rdata_w = 8'h00;

    // Reset held for two cycles
    tick();
    tick();
    check("rst_req",   {31'b0, mem_req},    32'h0);
    check("rst_addr",  mem_addr,            32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_pc",    pc,                  32'h0);
    check("rst_inst",  inst,                32'h0);
    check("rst_wrap_addr", mem_addr_w,      32'hFFFF_FFFC);
    check("rst_wrap_pc",   pc_w,            32'hFFFF_FFFC);

    // IDLE cycle: a redirect here must be ignored
    rst = 1'b0;  rst_w = 1'b0;  mem_gnt = 1'b1;  mem_gnt_w = 1'b1;
    br_flag = 1'b1;  br_target = 32'h0000_0300;
    check("idle_req", {31'b0, mem_req}, 32'h0);
    tick();
    br_flag = 1'b0;

    // c0..c3: byte requests with continuous grant
    for (int k = 0; k < 4; k++) begin
      check($sformatf("c%0d_req", k),  {31'b0, mem_req}, 32'h1);
      check($sformatf("c%0d_addr", k), mem_addr, k);
      check($sformatf("c%0d_waddr", k), mem_addr_w, 32'hFFFF_FFFC + k);
      tick();
    end
    // c4: DRAIN
    check("c4_req",   {31'b0, mem_req},    32'h0);
    check("c4_valid", {31'b0, inst_valid}, 32'h0);
    tick();
    // c5: instruction valid
    check("c5_valid", {31'b0, inst_valid}, 32'h1);
    check("c5_inst",  inst, 32'h0010_0513);
    check("c5_pc",    pc,   32'h0);
    check("wrap_valid", {31'b0, inst_valid_w}, 32'h1);
    check("wrap_inst",  inst_w, 32'h4433_2211);
    check("wrap_pc",    pc_w,   32'hFFFF_FFFC);

    // Decode stalls for three cycles (c5..c7)
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d_valid", k), {31'b0, inst_valid}, 32'h1);
      check($sformatf("stall%0d_inst", k),  inst, 32'h0010_0513);
      check($sformatf("stall%0d_pc", k),    pc,   32'h0);
      check($sformatf("stall%0d_req", k),   {31'b0, mem_req}, 32'h0);
      if (k == 0) begin
        tick();
        check("wrap_next_req",  {31'b0, mem_req_w}, 32'h1);
        check("wrap_next_addr", mem_addr_w, 32'h0);
        check("wrap_next_pc",   pc_w, 32'h0);
      end else begin
        tick();
      end
    end
    // c8: accept
    check("c8_valid", {31'b0, inst_valid}, 32'h1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // c9..: second fetch with grant withheld for two cycles at byte 2
    check("c9_req",   {31'b0, mem_req},    32'h1);
    check("c9_addr",  mem_addr,            32'h4);
    check("c9_valid", {31'b0, inst_valid}, 32'h0);
    tick();
    check("c10_addr", mem_addr, 32'h5);
    tick();
    check("c11_addr", mem_addr, 32'h6);
    mem_gnt = 1'b0;
    tick();
    check("c12_req",  {31'b0, mem_req}, 32'h1);
    check("c12_addr", mem_addr, 32'h6);
    tick();
    check("c13_addr", mem_addr, 32'h6);
    mem_gnt = 1'b1;
    tick();
    check("c14_addr", mem_addr, 32'h7);
    tick();
    check("c15_valid", {31'b0, inst_valid}, 32'h0);
    check("c15_req",   {31'b0, mem_req},    32'h0);
    tick();
    check("c16_valid", {31'b0, inst_valid}, 32'h1);
    check("c16_inst",  inst, 32'h0010_0093);
    check("c16_pc",    pc,   32'h4);

    // Redirect to 0x200 together with a transfer in HOLD
    inst_ready = 1'b1;  br_flag = 1'b1;  br_target = 32'h0000_0200;
    tick();
    inst_ready = 1'b0;  br_flag = 1'b0;
    check("br_hold_req",   {31'b0, mem_req},    32'h1);
    check("br_hold_addr",  mem_addr,            32'h200);
    check("br_hold_valid", {31'b0, inst_valid}, 32'h0);
    for (int k = 0; k < 5; k++) tick();
    check("c22_valid", {31'b0, inst_valid}, 32'h1);
    check("c22_inst",  inst, 32'h0000_006F);
    check("c22_pc",    pc,   32'h200);

    // Redirect to 0x103 while byte 1 of the fetch at 0x204 is granted
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("c23_addr", mem_addr, 32'h204);
    tick();
    check("c24_addr", mem_addr, 32'h205);
    br_flag = 1'b1;  br_target = 32'h0000_0103;
    tick();
    br_flag = 1'b0;
    check("br_req_req",  {31'b0, mem_req}, 32'h1);
    check("br_req_addr", mem_addr, 32'h100);
    tick();
    check("c26_addr",       mem_addr, 32'h101);
    check("stale_not_kept", inst,     32'h0000_005E);
    tick();
    tick();
    check("c28_addr", mem_addr, 32'h103);
    tick();
    check("c29_valid", {31'b0, inst_valid}, 32'h0);
    tick();
    check("c30_valid", {31'b0, inst_valid}, 32'h1);
    check("c30_inst",  inst, 32'h5634_12B7);
    check("c30_pc",    pc,   32'h100);

    // Reset asserted in the middle of a fetch
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("c31_addr", mem_addr, 32'h104);
    tick();
    check("c32_addr", mem_addr, 32'h105);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_req",   {31'b0, mem_req},    32'h0);
    check("mrst_addr",  mem_addr,            32'h0);
    check("mrst_valid", {31'b0, inst_valid}, 32'h0);
    check("mrst_pc",    pc,                  32'h0);
    check("mrst_inst",  inst,                32'h0);
    tick();
    check("restart_req",  {31'b0, mem_req}, 32'h1);
    check("restart_addr", mem_addr, 32'h0);
    for (int k = 0; k < 5; k++) tick();
    check("restart_valid", {31'b0, inst_valid}, 32'h1);
    check("restart_inst",  inst, 32'h0010_0513);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
